// File: rtl/core101_pkg.sv
// Shared Core101 definitions: branch condition codes and the EX/MEM entry.
package core101_pkg;

   localparam int unsigned DATA_W_P = 32;
   localparam int unsigned REG_W_P  = 5;

   // Branch condition codes; 110/111 are reserved and behave as BR_NONE.
   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b001;
   localparam logic [2:0] BR_NE   = 3'b010;
   localparam logic [2:0] BR_LT   = 3'b011;
   localparam logic [2:0] BR_GE   = 3'b100;
   localparam logic [2:0] BR_JUMP = 3'b101;

   // One buffered entry travelling from EX to MEM.
   typedef struct packed {
      logic [DATA_W_P-1:0] result;
      logic [REG_W_P-1:0]  rd;
      logic                wb_en;
   } entry_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision from the ALU flags.
// For the conditional codes, EX has already computed A-B. Signed overflow is
// not corrected, so the flags are used exactly as the ALU produced them.
module branch_resolve
   import core101_pkg::*;
(
   input  logic [2:0] branch_op_i,
   input  logic       neg_i,
   input  logic       zero_i,
   output logic       taken_o
);

   // Decode the condition code against the flags; unknown codes are not taken.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      taken_o = 1'b0;
      case (branch_op_i)
         BR_EQ:   taken_o = zero_i;
         BR_NE:   taken_o = !zero_i;
         BR_LT:   taken_o = neg_i;
         BR_GE:   taken_o = !neg_i;
         BR_JUMP: taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX -> MEM pipeline buffer for Core101.
// Holds the ALU result, destination register and write enable, and raises a
// one-cycle redirect pulse for taken branches on the cycle after acceptance.
// Build option EX_MEM_SKID_EN: adds a skid register so that ex_ready_out is a
// pure register (1 iff skid empty). Without it, ex_ready_out is derived
// combinationally from mem_ready_in and only the head register exists.
module ex_mem_buffer
   import core101_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              ex_valid_in,
   output logic              ex_ready_out,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic              alu_neg_in,
   input  logic              alu_zero_in,
   input  logic [REG_W-1:0]  rd_addr_in,
   input  logic              wb_en_in,
   input  logic [2:0]        branch_op_in,
   input  logic [DATA_W-1:0] branch_target_in,
   input  logic              flush_in,
   output logic              mem_valid_out,
   input  logic              mem_ready_in,
   output logic [DATA_W-1:0] mem_result_out,
   output logic [REG_W-1:0]  mem_rd_addr_out,
   output logic              mem_wb_en_out,
   output logic              branch_taken_out,
   output logic [DATA_W-1:0] branch_target_out
);

   entry_t            in_entry;
   entry_t            head_q, head_d;
   logic              head_vld_q, head_vld_d;
   logic              taken;
   logic              accept;
   logic              held;
   logic              branch_taken_q, branch_taken_d;
   logic [DATA_W-1:0] branch_target_q, branch_target_d;

   assign in_entry.result = alu_result_in;
   assign in_entry.rd     = rd_addr_in;
   assign in_entry.wb_en  = wb_en_in;

   assign accept = ex_valid_in && ex_ready_out;
   assign held   = head_vld_q && !mem_ready_in;

   branch_resolve u_branch_resolve (
      .branch_op_i (branch_op_in),
      .neg_i       (alu_neg_in),
      .zero_i      (alu_zero_in),
      .taken_o     (taken)
   );

`ifdef EX_MEM_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_vld_q, skid_vld_d;

   assign ex_ready_out = !skid_vld_q;

   // Head/skid next state: flush wins, a held head diverts the accept into the
   // skid, otherwise the skid (if any) refills the head before a new accept.
   always_comb begin
      head_d     = head_q;
      head_vld_d = head_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush_in) begin
         head_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (held) begin
         if (accept) begin
            skid_d     = in_entry;
            skid_vld_d = 1'b1;
         end
      end else if (skid_vld_q) begin
         // Head is being dequeued; ready was low, so no accept can coincide.
         head_d     = skid_q;
         head_vld_d = 1'b1;
         skid_vld_d = 1'b0;
      end else if (accept) begin
         head_d     = in_entry;
         head_vld_d = 1'b1;
      end else begin
         head_vld_d = 1'b0;
      end
   end

   // Skid register; only its valid bit affects behaviour, data is cleared for tidiness.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end
`else
   // Ready whenever the head is empty or leaving on this edge.
   assign ex_ready_out = !head_vld_q || mem_ready_in;

   // Head next state: flush wins, an accept replaces the head, a lone dequeue empties it.
   always_comb begin
      head_d     = head_q;
      head_vld_d = head_vld_q;
      if (flush_in) begin
         head_vld_d = 1'b0;
      end else if (accept) begin
         head_d     = in_entry;
         head_vld_d = 1'b1;
      end else if (head_vld_q && mem_ready_in) begin
         head_vld_d = 1'b0;
      end
   end
`endif

   // Redirect pulse for an accepted taken branch; the target holds between pulses.
   always_comb begin
      branch_taken_d  = accept && taken && !flush_in;
      branch_target_d = branch_taken_d ? branch_target_in : branch_target_q;
   end

   // Head and branch registers.
   always_ff @(posedge clock_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset_in) begin
         // NOTE: data registers are reset too, because MEM sees zeroed fields out of reset.
         head_q          <= '0;
         head_vld_q      <= 1'b0;
         branch_taken_q  <= 1'b0;
         branch_target_q <= '0;
      end else begin
         head_q          <= head_d;
         head_vld_q      <= head_vld_d;
         branch_taken_q  <= branch_taken_d;
         branch_target_q <= branch_target_d;
      end
   end

   assign mem_valid_out     = head_vld_q;
   assign mem_result_out    = head_q.result;
   assign mem_rd_addr_out   = head_q.rd;
   assign mem_wb_en_out     = head_q.wb_en;
   assign branch_taken_out  = branch_taken_q;
   assign branch_target_out = branch_target_q;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed testbench for ex_mem_buffer. Works with and without EX_MEM_SKID_EN.
module tb_ex_mem_buffer;

   logic        clk;
   logic        reset_in;
   logic        ex_valid_in;
   logic        ex_ready_out;
   logic [31:0] alu_result_in;
   logic        alu_neg_in;
   logic        alu_zero_in;
   logic [4:0]  rd_addr_in;
   logic        wb_en_in;
   logic [2:0]  branch_op_in;
   logic [31:0] branch_target_in;
   logic        flush_in;
   logic        mem_valid_out;
   logic        mem_ready_in;
   logic [31:0] mem_result_out;
   logic [4:0]  mem_rd_addr_out;
   logic        mem_wb_en_out;
   logic        branch_taken_out;
   logic [31:0] branch_target_out;

   int          n_tests;
   int          n_fail;
   logic [31:0] last_target;

   ex_mem_buffer dut (
      .clock_in          (clk),
      .reset_in          (reset_in),
      .ex_valid_in       (ex_valid_in),
      .ex_ready_out      (ex_ready_out),
      .alu_result_in     (alu_result_in),
      .alu_neg_in        (alu_neg_in),
      .alu_zero_in       (alu_zero_in),
      .rd_addr_in        (rd_addr_in),
      .wb_en_in          (wb_en_in),
      .branch_op_in      (branch_op_in),
      .branch_target_in  (branch_target_in),
      .flush_in          (flush_in),
      .mem_valid_out     (mem_valid_out),
      .mem_ready_in      (mem_ready_in),
      .mem_result_out    (mem_result_out),
      .mem_rd_addr_out   (mem_rd_addr_out),
      .mem_wb_en_out     (mem_wb_en_out),
      .branch_taken_out  (branch_taken_out),
      .branch_target_out (branch_target_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] res, input logic [4:0] rd, input logic wb,
                        input logic [2:0] op, input logic neg, input logic zero,
                        input logic [31:0] tgt);
      ex_valid_in      = 1'b1;
      alu_result_in    = res;
      rd_addr_in       = rd;
      wb_en_in         = wb;
      branch_op_in     = op;
      alu_neg_in       = neg;
      alu_zero_in      = zero;
      branch_target_in = tgt;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".valid"},  {31'd0, mem_valid_out},    32'd0);
      check({tag, ".ready"},  {31'd0, ex_ready_out},     32'd1);
      check({tag, ".taken"},  {31'd0, branch_taken_out}, 32'd0);
      check({tag, ".result"}, mem_result_out,            32'd0);
      check({tag, ".rd"},     {27'd0, mem_rd_addr_out},  32'd0);
      check({tag, ".wb_en"},  {31'd0, mem_wb_en_out},    32'd0);
      check({tag, ".target"}, branch_target_out,         32'd0);
   endtask

   // One branch entry with MEM ready: checks the pulse, target, entry fields, pulse end.
   task automatic br_case(input string tag, input logic [2:0] op, input logic neg,
                          input logic zero, input logic [31:0] tgt, input logic wb,
                          input logic [4:0] rd, input logic exp_taken);
      offer(32'h55, rd, wb, op, neg, zero, tgt);
      step();
      if (exp_taken) last_target = tgt;
      check({tag, ".taken"},  {31'd0, branch_taken_out}, {31'd0, exp_taken});
      check({tag, ".target"}, branch_target_out,         last_target);
      check({tag, ".valid"},  {31'd0, mem_valid_out},    32'd1);
      check({tag, ".rd"},     {27'd0, mem_rd_addr_out},  {27'd0, rd});
      check({tag, ".wb_en"},  {31'd0, mem_wb_en_out},    {31'd0, wb});
      ex_valid_in = 1'b0;
      step();
      check({tag, ".pulse_end"}, {31'd0, branch_taken_out}, 32'd0);
      check({tag, ".hold"},      branch_target_out,         last_target);
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      last_target      = 32'd0;
      reset_in         = 1'b1;
      ex_valid_in      = 1'b0;
      alu_result_in    = '0;
      alu_neg_in       = 1'b0;
      alu_zero_in      = 1'b0;
      rd_addr_in       = '0;
      wb_en_in         = 1'b0;
      branch_op_in     = 3'b000;
      branch_target_in = '0;
      flush_in         = 1'b0;
      mem_ready_in     = 1'b1;

      // Reset state
      step();
      step();
      check_reset_state("reset");
      reset_in = 1'b0;

      // Stream of four entries with MEM always ready
      for (int i = 0; i < 4; i++) begin
         offer(32'h10 + i, 5'(i + 2), 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
         step();
         check($sformatf("stream%0d.valid", i),  {31'd0, mem_valid_out}, 32'd1);
         check($sformatf("stream%0d.result", i), mem_result_out,         32'h10 + i);
         check($sformatf("stream%0d.rd", i),     {27'd0, mem_rd_addr_out}, 32'(i + 2));
         check($sformatf("stream%0d.ready", i),  {31'd0, ex_ready_out},  32'd1);
      end
      ex_valid_in = 1'b0;
      step();
      check("stream.drain", {31'd0, mem_valid_out}, 32'd0);

      // Back-pressure: 0xA into head, 0xB offered while MEM stalls
      mem_ready_in = 1'b0;
      offer(32'hA, 5'd3, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
      check("bp.head_a", mem_result_out, 32'hA);
`ifdef EX_MEM_SKID_EN
      check("bp.ready_skid_free", {31'd0, ex_ready_out}, 32'd1);
`else
      check("bp.ready_head_held", {31'd0, ex_ready_out}, 32'd0);
`endif
      offer(32'hB, 5'd4, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
      check("bp.hold_a",  mem_result_out,             32'hA);
      check("bp.ready0",  {31'd0, ex_ready_out},      32'd0);
`ifdef EX_MEM_SKID_EN
      ex_valid_in = 1'b0;
`endif
      step();
      check("bp.stable_a",     mem_result_out,          32'hA);
      check("bp.stable_valid", {31'd0, mem_valid_out}, 32'd1);
      check("bp.stable_ready", {31'd0, ex_ready_out},  32'd0);
      mem_ready_in = 1'b1;
      step();
      ex_valid_in = 1'b0;
      check("bp.then_b",  mem_result_out,         32'hB);
      check("bp.valid_b", {31'd0, mem_valid_out}, 32'd1);
      check("bp.ready1",  {31'd0, ex_ready_out},  32'd1);
      step();
      check("bp.empty", {31'd0, mem_valid_out}, 32'd0);

      // Branch resolution
      br_case("beq_z1",  3'b001, 1'b0, 1'b1, 32'h100, 1'b0, 5'd0, 1'b1);
      br_case("bne_z1",  3'b010, 1'b0, 1'b1, 32'h200, 1'b0, 5'd0, 1'b0);
      br_case("blt_n1",  3'b011, 1'b1, 1'b0, 32'h300, 1'b0, 5'd0, 1'b1);
      br_case("bge_n1",  3'b100, 1'b1, 1'b0, 32'h400, 1'b0, 5'd0, 1'b0);
      br_case("jump",    3'b101, 1'b0, 1'b0, 32'h500, 1'b1, 5'd1, 1'b1);
      br_case("op110",   3'b110, 1'b0, 1'b1, 32'h700, 1'b0, 5'd2, 1'b0);

      // Flush with the buffer full and a taken BEQ offered in the same cycle
      mem_ready_in = 1'b0;
      offer(32'hC, 5'd5, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
`ifdef EX_MEM_SKID_EN
      offer(32'hD, 5'd6, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
      check("flush.pre_ready", {31'd0, ex_ready_out}, 32'd0);
`endif
      mem_ready_in = 1'b1;
      flush_in     = 1'b1;
      offer(32'h66, 5'd7, 1'b1, 3'b001, 1'b0, 1'b1, 32'h600);
      step();
      check("flush.valid",  {31'd0, mem_valid_out},    32'd0);
      check("flush.taken",  {31'd0, branch_taken_out}, 32'd0);
      check("flush.ready",  {31'd0, ex_ready_out},     32'd1);
      check("flush.target", branch_target_out,         last_target);
      flush_in    = 1'b0;
      ex_valid_in = 1'b0;
      step();
      check("flush.after_valid", {31'd0, mem_valid_out},    32'd0);
      check("flush.after_taken", {31'd0, branch_taken_out}, 32'd0);

      // Flush with a held head and a taken BEQ offered while MEM stalls
      mem_ready_in = 1'b0;
      offer(32'hE, 5'd8, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
      flush_in = 1'b1;
      offer(32'h77, 5'd9, 1'b0, 3'b001, 1'b0, 1'b1, 32'h800);
      step();
      check("flush2.valid",  {31'd0, mem_valid_out},    32'd0);
      check("flush2.taken",  {31'd0, branch_taken_out}, 32'd0);
      check("flush2.target", branch_target_out,         last_target);
      flush_in     = 1'b0;
      ex_valid_in  = 1'b0;
      mem_ready_in = 1'b1;
      step();

      // Reset while entries are held, then first accept after release
      mem_ready_in = 1'b0;
      offer(32'h20, 5'd10, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
      offer(32'h21, 5'd11, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
      ex_valid_in = 1'b0;
      reset_in    = 1'b1;
      step();
      check_reset_state("midreset");
      reset_in     = 1'b0;
      mem_ready_in = 1'b1;
      offer(32'h30, 5'd12, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
      step();
      ex_valid_in = 1'b0;
      check("post_reset.valid",  {31'd0, mem_valid_out}, 32'd1);
      check("post_reset.result", mem_result_out,         32'h30);
      step();
      check("post_reset.drain", {31'd0, mem_valid_out}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
